// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between four requesters, the write arbiter and a shared FIFO write port.
// The slave modport is the arbiter's view; master is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [3:0]              req;
    logic [4*DATA_WIDTH-1:0] din;
    logic                    fifo_full;
    logic [3:0]              gnt;
    logic [3:0]              ack;
    logic                    fifo_wr_en;
    logic [DATA_WIDTH-1:0]   fifo_din;
    logic                    busy;

    modport master (
        output req, din, fifo_full,
        input  gnt, ack, fifo_wr_en, fifo_din, busy
    );

    modport slave (
        input  req, din, fifo_full,
        output gnt, ack, fifo_wr_en, fifo_din, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one of four requesters burst access to a shared FIFO
// write port, releasing on request drop or after BURST_MAX accepted words.
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BURST_MAX  = 8
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [7:0] BurstLast = 8'(BURST_MAX - 1);

    state_e     state_q;
    logic [3:0] gnt_q;
    logic [1:0] gnt_idx_q;
    logic [1:0] last_id_q;
    logic [7:0] burst_cnt_q;
    logic       busy_q;

    logic [1:0] rr_idx;
    logic       rr_found;
    logic       granted_req;
    logic       accept;

    // Scan downward in distance so the nearest requester after last_id wins.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int k = 4; k > 0; k--) begin
            if (bus.req[last_id_q + 2'(k)]) begin
                rr_idx   = last_id_q + 2'(k);
                rr_found = 1'b1;
            end
        end
    end

    assign granted_req = bus.req[gnt_idx_q];
    assign accept      = (state_q == StGrant) && granted_req && !bus.fifo_full;

    assign bus.gnt        = gnt_q;
    assign bus.busy       = busy_q;
    assign bus.ack        = accept ? gnt_q : 4'b0000;
    assign bus.fifo_wr_en = accept;
    assign bus.fifo_din   = (state_q == StGrant) ?
                            bus.din[gnt_idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            last_id_q   <= 2'd3;
            burst_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rr_found) begin
                        state_q     <= StGrant;
                        gnt_q       <= 4'b0001 << rr_idx;
                        gnt_idx_q   <= rr_idx;
                        burst_cnt_q <= '0;
                        busy_q      <= 1'b1;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                StGrant: begin
                    if (!granted_req) begin
                        state_q   <= StIdle;
                        last_id_q <= gnt_idx_q;
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                    end else if (accept) begin
                        burst_cnt_q <= burst_cnt_q + 8'd1;
                        if (burst_cnt_q == BurstLast) begin
                            state_q   <= StIdle;
                            last_id_q <= gnt_idx_q;
                            gnt_q     <= '0;
                            busy_q    <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each requester data word and of the FIFO write data.
REQ-002 Parameter BURST_MAX, default 8, legal range 1..255: maximum words accepted per grant before forced release.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: asynchronous, active-high reset.
REQ-005 Port req  input  4: req[i]=1 means requester i presents a valid word on its din slice.
REQ-006 Port din  input  4*DATA_WIDTH: packed data; requester i owns bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 Port fifo_full  input  1: write-full flag from the shared synchronous FIFO.
REQ-008 Port gnt  output  4: registered one-hot grant; all zero when no grant is active.
REQ-009 Port ack  output  4: word of requester i accepted this cycle.
REQ-010 Port fifo_wr_en  output  1: write strobe to the FIFO.
REQ-011 Port fifo_din  output  DATA_WIDTH: write data to the FIFO.
REQ-012 Port busy  output  1: high while the FSM is in GRANT.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-014 In IDLE with req != 0, the block SHALL select one requester by round-robin, searching upward from last_id+1 modulo 4, then load gnt, clear burst_cnt and enter GRANT on the next edge.
REQ-015 In IDLE with req == 0, the block SHALL remain in IDLE with gnt = 0.
REQ-016 ack[i] SHALL be combinational: state==GRANT AND gnt[i] AND req[i] AND NOT fifo_full; all other ack bits SHALL be 0.
REQ-017 fifo_wr_en SHALL equal the OR of ack; fifo_din SHALL be the din slice of the granted requester while in GRANT, and 0 otherwise.
REQ-018 Each ack cycle SHALL increment burst_cnt (8-bit) by 1; burst_cnt SHALL be held while fifo_full=1.
REQ-019 In GRANT, if req of the granted requester is 0, the block SHALL return to IDLE on the next edge, set last_id to the granted index and clear gnt.
REQ-020 In GRANT, an ack with burst_cnt == BURST_MAX-1 SHALL return to IDLE on the next edge (after BURST_MAX words), set last_id and clear gnt.
REQ-021 fifo_full=1 in GRANT SHALL stall without releasing: gnt held, no ack, no write, no count change.
REQ-022 A release SHALL always pass through one IDLE cycle; the next grant appears two edges after the final accepted word or the req drop.
REQ-023 Requests from non-granted requesters SHALL NOT affect gnt, ack or burst_cnt while in GRANT.
REQ-024 Each accepted word SHALL be written exactly once, in acceptance order; no word is accepted while fifo_full=1.

Reset
REQ-025 While rst=1, the block SHALL immediately and asynchronously force: state IDLE, gnt=0, ack=0, fifo_wr_en=0, fifo_din=0, busy=0, burst_cnt=0, last_id=3 (requester 0 first priority).
REQ-026 A reset asserted mid-burst SHALL drop the grant at once and discard the count; arbitration restarts from requester 0 after release.
REQ-027 The first rising clk edge after rst falls SHALL be evaluated as an IDLE cycle.

Verification
REQ-028 After reset, req=4'b1111 held, fifo_full=0, BURST_MAX=8 -> gnt sequence 0001,0010,0100,1000,0001; exactly 8 acks per grant; one gnt=0 cycle between grants.
REQ-029 req=4'b0100 for 3 cycles then 0 -> gnt=0100; 3 writes with din[2] data in order; IDLE two edges after the last word; next arbitration starts at requester 3.
REQ-030 Requester 1 granted, fifo_full=1 for 5 cycles mid-burst -> fifo_wr_en=0 and gnt=0010 held for those 5 cycles; remaining words written after full drops; total still 8.
REQ-031 BURST_MAX=1, req=4'b0011 -> grants alternate 0001/0010 with one word each and an IDLE cycle between them.
REQ-032 rst pulsed while requester 2 is at burst_cnt=4 -> all outputs 0 within the reset cycle; after release with req=4'b0101, requester 0 is granted first.
REQ-033 Scoreboard, random req/din/fifo_full for 10000 cycles -> FIFO write stream equals the per-requester accepted words in order; gnt is one-hot or zero; no burst exceeds BURST_MAX.
